// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared definitions for the ALU issue stage.
//   - RV32I major opcode constants
//   - ALU operation select codes (funct3-aligned, matching the team ALU)
//   - issue_t: decoded payload handed from alu_issue_decode to alu_issue
package alu_issue_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SLL  = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SR   = 3'b101;
  localparam logic [2:0] ALU_OR   = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [2:0]  opsel;
    logic        sub;
    logic        uns;
    logic        arith;
    logic        branch;
    logic        illegal;
    logic [31:0] op1;
    logic [31:0] op2;
  } issue_t;

  function automatic logic [31:0] sext12(input logic [11:0] imm);
    return {{20{imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// alu_issue_decode: combinational RV32I decode into an ALU issue payload.
//   inst, pc, rs1_data, rs2_data : instruction word, its address, operands
//   payload                      : ALU controls/operands plus branch/illegal
module alu_issue_decode
  import alu_issue_pkg::*;
(
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output issue_t      payload
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_rs1_idx;
  issue_t     dec;
  logic       bad;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  // Register indices are resolved upstream; only the data is consumed here.
  assign unused_rs1_idx = ^inst[19:15];

  always_comb begin
    dec = '0;
    bad = 1'b0;
    case (opcode)
      OP: begin
        dec.opsel = funct3;
        dec.op1   = rs1_data;
        dec.op2   = rs2_data;
        dec.sub   = (funct3 == ALU_ADD) && funct7[5];
        dec.arith = (funct3 == ALU_SR) && funct7[5];
        dec.uns   = (funct3 == ALU_SLTU);
        bad = !((funct7 == F7_BASE) ||
                ((funct7 == F7_ALT) && ((funct3 == ALU_ADD) || (funct3 == ALU_SR))));
      end
      OP_IMM: begin
        dec.opsel = funct3;
        dec.op1   = rs1_data;
        dec.uns   = (funct3 == ALU_SLTU);
        if ((funct3 == ALU_SLL) || (funct3 == ALU_SR)) begin
          // Shift immediates carry only the shamt; imm[11:5] is a function field.
          dec.op2   = {27'b0, inst[24:20]};
          dec.arith = (funct3 == ALU_SR) && funct7[5];
          bad = !((funct7 == F7_BASE) || ((funct7 == F7_ALT) && (funct3 == ALU_SR)));
        end else begin
          dec.op2 = sext12(inst[31:20]);
        end
      end
      LOAD: begin
        dec.op1 = rs1_data;
        dec.op2 = sext12(inst[31:20]);
      end
      STORE: begin
        dec.op1 = rs1_data;
        dec.op2 = sext12({inst[31:25], inst[11:7]});
      end
      LUI: begin
        dec.op2 = {inst[31:12], 12'b0};
      end
      AUIPC: begin
        dec.op1 = pc;
        dec.op2 = {inst[31:12], 12'b0};
      end
      JAL, JALR: begin
        dec.op1 = pc;
        dec.op2 = 32'd4;
      end
      BRANCH: begin
        dec.op1    = rs1_data;
        dec.op2    = rs2_data;
        dec.sub    = 1'b1;
        dec.branch = 1'b1;
        dec.uns    = (funct3[2:1] == 2'b11);
        bad = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  assign payload = dec;

endmodule

// File: rtl/alu_issue.sv
// alu_issue: accepts RV32I instructions with operands, decodes them and
// issues ALU requests over a valid/ready handshake, counting transfers.
//   i_clk, i_rst_n                    : clock, async active-low reset
//   i_valid/o_ready, i_inst, i_pc,
//   i_rs1_data, i_rs2_data            : upstream instruction handshake
//   o_valid/i_ready, o_opsel, o_sub,
//   o_unsigned, o_arith, o_op1, o_op2,
//   o_branch, o_illegal               : downstream ALU request
//   o_issue_cnt                       : completed output transfers (wraps)
// Build option: define ALU_ISSUE_SKID_EN for a two-entry skid buffer with
// a registered o_ready; otherwise a single register with combinational
// o_ready.
module alu_issue
  import alu_issue_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_rs1_data,
  input  logic [31:0] i_rs2_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [2:0]  o_opsel,
  output logic        o_sub,
  output logic        o_unsigned,
  output logic        o_arith,
  output logic [31:0] o_op1,
  output logic [31:0] o_op2,
  output logic        o_branch,
  output logic        o_illegal,
  output logic [15:0] o_issue_cnt
);

  issue_t      dec_payload;
  issue_t      out_q;
  logic        out_valid_q;
  logic [15:0] cnt_q;
  logic        in_fire;
  logic        out_fire;

  alu_issue_decode u_decode (
    .inst     (i_inst),
    .pc       (i_pc),
    .rs1_data (i_rs1_data),
    .rs2_data (i_rs2_data),
    .payload  (dec_payload)
  );

  assign in_fire  = i_valid && o_ready;
  assign out_fire = out_valid_q && i_ready;

`ifdef ALU_ISSUE_SKID_EN
  issue_t skid_q;
  logic   skid_valid_q;
  logic   ready_q;

  // A word accepted while the output stalls parks in skid_q; o_ready then
  // drops until the output drains, so i_ready never reaches o_ready.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else if (skid_valid_q) begin
      if (i_ready) begin
        out_q        <= skid_q;
        skid_valid_q <= 1'b0;
        ready_q      <= 1'b1;
      end
    end else begin
      ready_q <= 1'b1;
      if (in_fire) begin
        if (out_valid_q && !i_ready) begin
          skid_q       <= dec_payload;
          skid_valid_q <= 1'b1;
          ready_q      <= 1'b0;
        end else begin
          out_q       <= dec_payload;
          out_valid_q <= 1'b1;
        end
      end else if (i_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign o_ready = ready_q;
`else
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (in_fire) begin
      out_q       <= dec_payload;
      out_valid_q <= 1'b1;
    end else if (i_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign o_ready = !out_valid_q || i_ready;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (out_fire) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign o_valid     = out_valid_q;
  assign o_opsel     = out_q.opsel;
  assign o_sub       = out_q.sub;
  assign o_unsigned  = out_q.uns;
  assign o_arith     = out_q.arith;
  assign o_op1       = out_q.op1;
  assign o_op2       = out_q.op2;
  assign o_branch    = out_q.branch;
  assign o_illegal   = out_q.illegal;
  assign o_issue_cnt = cnt_q;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed self-checking bench for alu_issue.
module tb_alu_issue;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_inst;
  logic [31:0] i_pc;
  logic [31:0] i_rs1_data;
  logic [31:0] i_rs2_data;
  logic        o_valid;
  logic        i_ready;
  logic [2:0]  o_opsel;
  logic        o_sub;
  logic        o_unsigned;
  logic        o_arith;
  logic [31:0] o_op1;
  logic [31:0] o_op2;
  logic        o_branch;
  logic        o_illegal;
  logic [15:0] o_issue_cnt;

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_cnt = 16'd0;

  alu_issue dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_inst      (i_inst),
    .i_pc        (i_pc),
    .i_rs1_data  (i_rs1_data),
    .i_rs2_data  (i_rs2_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_opsel     (o_opsel),
    .o_sub       (o_sub),
    .o_unsigned  (o_unsigned),
    .o_arith     (o_arith),
    .o_op1       (o_op1),
    .o_op2       (o_op2),
    .o_branch    (o_branch),
    .o_illegal   (o_illegal),
    .o_issue_cnt (o_issue_cnt)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one instruction and return #1 after the edge that accepts it.
  task automatic send(input logic [31:0] inst, input logic [31:0] pc,
                      input logic [31:0] rs1, input logic [31:0] rs2);
    int n;
    @(negedge i_clk);
    i_valid = 1'b1; i_inst = inst; i_pc = pc; i_rs1_data = rs1; i_rs2_data = rs2;
    #1;
    n = 0;
    while (!o_ready && n < 50) begin
      @(negedge i_clk); #1; n++;
    end
    if (n >= 50) begin
      tests++; fails++;
      $display("FAIL send_timeout: observed o_ready 0 expected 1");
    end
    @(posedge i_clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [2:0] opsel, input logic sub,
                            input logic uns, input logic arith, input logic branch,
                            input logic illegal, input logic [31:0] op1, input logic [31:0] op2);
    chk({tag, ".valid"},   32'(o_valid),    32'd1);
    chk({tag, ".opsel"},   32'(o_opsel),    32'(opsel));
    chk({tag, ".sub"},     32'(o_sub),      32'(sub));
    chk({tag, ".uns"},     32'(o_unsigned), 32'(uns));
    chk({tag, ".arith"},   32'(o_arith),    32'(arith));
    chk({tag, ".branch"},  32'(o_branch),   32'(branch));
    chk({tag, ".illegal"}, 32'(o_illegal),  32'(illegal));
    chk({tag, ".op1"},     o_op1,           op1);
    chk({tag, ".op2"},     o_op2,           op2);
  endtask

  // Issue with i_ready high, check payload, then check the transfer count.
  task automatic run_vec(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [2:0] opsel, input logic sub, input logic uns,
                         input logic arith, input logic branch, input logic illegal,
                         input logic [31:0] op1, input logic [31:0] op2);
    send(inst, pc, rs1, rs2);
    expect_out(tag, opsel, sub, uns, arith, branch, illegal, op1, op2);
    @(posedge i_clk); #1;
    exp_cnt = exp_cnt + 16'd1;
    chk({tag, ".cnt"}, 32'(o_issue_cnt), 32'(exp_cnt));
  endtask

  function automatic logic [31:0] addi_x1(input logic [11:0] imm);
    return {imm, 5'd1, 3'b000, 5'd1, 7'b0010011};
  endfunction

  initial begin
    int sent;
    int got;
    logic prev_stall;
    logic [31:0] prev_op1;
    logic [31:0] prev_op2;

    i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_inst = '0; i_pc = '0; i_rs1_data = '0; i_rs2_data = '0;
    #1;
    chk("rst.valid", 32'(o_valid), 32'd0);
    chk("rst.cnt",   32'(o_issue_cnt), 32'd0);
    chk("rst.op1",   o_op1, 32'd0);
    chk("rst.op2",   o_op2, 32'd0);
    chk("rst.opsel", 32'(o_opsel), 32'd0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk); i_rst_n = 1'b1;
    @(negedge i_clk); @(negedge i_clk); #1;
    chk("rst.ready", 32'(o_ready), 32'd1);

    //       tag      inst          pc            rs1           rs2           op sub u ar br il op1           op2
    run_vec("add",   32'h002081B3, 32'h0,        32'd5,        32'd7,        3'b000, 0, 0, 0, 0, 0, 32'd5,        32'd7);
    run_vec("srai",  32'h40315093, 32'h0,        32'h80000000, 32'd0,        3'b101, 0, 0, 1, 0, 0, 32'h80000000, 32'd3);
    run_vec("sub",   32'h402081B3, 32'h0,        32'd9,        32'd4,        3'b000, 1, 0, 0, 0, 0, 32'd9,        32'd4);
    run_vec("bltu",  32'h0020E063, 32'h0,        32'd1,        32'd2,        3'b000, 1, 1, 0, 1, 0, 32'd1,        32'd2);
    run_vec("lui",   32'h123450B7, 32'h40,       32'hDEADBEEF, 32'd0,        3'b000, 0, 0, 0, 0, 0, 32'd0,        32'h12345000);
    run_vec("allf",  32'hFFFFFFFF, 32'h44,       32'h55,       32'h66,       3'b000, 0, 0, 0, 0, 1, 32'd0,        32'd0);
    run_vec("sltiu", 32'hFFF0B093, 32'h0,        32'h10,       32'd0,        3'b011, 0, 1, 0, 0, 0, 32'h10,       32'hFFFFFFFF);
    run_vec("sw",    32'hFE20AE23, 32'h0,        32'h200,      32'h77,       3'b000, 0, 0, 0, 0, 0, 32'h200,      32'hFFFFFFFC);
    run_vec("auipc", 32'h00001097, 32'h1000,     32'h9,        32'd0,        3'b000, 0, 0, 0, 0, 0, 32'h1000,     32'h1000);
    run_vec("jal",   32'h0000006F, 32'h2000,     32'h9,        32'd0,        3'b000, 0, 0, 0, 0, 0, 32'h2000,     32'd4);
    run_vec("brf3",  32'h0020A063, 32'h0,        32'd1,        32'd2,        3'b000, 0, 0, 0, 0, 1, 32'd0,        32'd0);
    run_vec("mul",   32'h022081B3, 32'h0,        32'd3,        32'd4,        3'b000, 0, 0, 0, 0, 1, 32'd0,        32'd0);
    run_vec("sllsb", 32'h402091B3, 32'h0,        32'd3,        32'd4,        3'b000, 0, 0, 0, 0, 1, 32'd0,        32'd0);
    run_vec("srli",  32'h00315093, 32'h0,        32'h80000000, 32'd0,        3'b101, 0, 0, 0, 0, 0, 32'h80000000, 32'd3);

    // Backpressure: payload must hold while stalled.
    @(negedge i_clk); i_ready = 1'b0;
    send(32'h002081B3, 32'h0, 32'h11, 32'h22);
    repeat (3) begin
      @(posedge i_clk); #1;
      chk("stall.valid", 32'(o_valid), 32'd1);
      chk("stall.op1",   o_op1, 32'h11);
      chk("stall.op2",   o_op2, 32'h22);
      chk("stall.cnt",   32'(o_issue_cnt), 32'(exp_cnt));
    end
    @(negedge i_clk); i_ready = 1'b1;
    @(posedge i_clk); #1;
    exp_cnt = exp_cnt + 16'd1;
    chk("stall.rel.cnt",   32'(o_issue_cnt), 32'(exp_cnt));
    chk("stall.rel.valid", 32'(o_valid), 32'd0);

    // Stream of 20 with random i_ready: order, no loss/duplication, hold.
    sent = 0; got = 0; prev_stall = 1'b0; prev_op1 = '0; prev_op2 = '0;
    for (int cyc = 0; cyc < 600 && got < 20; cyc++) begin
      @(negedge i_clk);
      i_ready = 1'($urandom_range(0, 1));
      if (sent < 20) begin
        i_valid = 1'b1;
        i_inst = addi_x1(12'(sent));
        i_rs1_data = 32'h100 + 32'(sent);
      end else begin
        i_valid = 1'b0;
      end
      #1;
      if (prev_stall) begin
        chk("hold.valid", 32'(o_valid), 32'd1);
        chk("hold.op1",   o_op1, prev_op1);
        chk("hold.op2",   o_op2, prev_op2);
      end
      if (o_valid && i_ready) begin
        chk("order.op1", o_op1, 32'h100 + 32'(got));
        chk("order.op2", o_op2, 32'(got));
        got++;
      end
      if (i_valid && o_ready) sent++;
      prev_stall = o_valid && !i_ready;
      prev_op1 = o_op1;
      prev_op2 = o_op2;
      @(posedge i_clk);
    end
    @(negedge i_clk); i_valid = 1'b0; i_ready = 1'b1; #1;
    chk("stream.got",   32'(got), 32'd20);
    chk("stream.empty", 32'(o_valid), 32'd0);
    exp_cnt = exp_cnt + 16'd20;
    chk("stream.cnt",   32'(o_issue_cnt), 32'(exp_cnt));

    // Reset while a stalled request is in flight.
    @(negedge i_clk); i_ready = 1'b0;
    send(32'h002081B3, 32'h0, 32'h33, 32'h44);
    chk("mid.pre.valid", 32'(o_valid), 32'd1);
    @(negedge i_clk); #2;
    i_rst_n = 1'b0;
    #1;
    chk("mid.valid", 32'(o_valid), 32'd0);
    chk("mid.cnt",   32'(o_issue_cnt), 32'd0);
    chk("mid.op1",   o_op1, 32'd0);
    chk("mid.op2",   o_op2, 32'd0);
    @(negedge i_clk); i_rst_n = 1'b1; i_ready = 1'b1;
    repeat (3) begin
      @(posedge i_clk); #1;
      chk("post.valid", 32'(o_valid), 32'd0);
      chk("post.cnt",   32'(o_issue_cnt), 32'd0);
    end
    chk("post.ready", 32'(o_ready), 32'd1);
    exp_cnt = 16'd0;
    run_vec("post.add", 32'h002081B3, 32'h0, 32'd5, 32'd7, 3'b000, 0, 0, 0, 0, 0, 32'd5, 32'd7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
